// File: rtl/wb_data_slave_if.sv
// wb_data_slave_if: Wishbone data-slave bus bundle with master/slave views
interface wb_data_slave_if;
    logic        s_cyc_i;
    logic        s_stb_i;
    logic        s_we_i;
    logic [63:0] s_adr_i;
    logic [7:0]  s_sel_i;
    logic [63:0] s_dat_i;
    logic [63:0] s_dat_o;
    logic        s_ack_o;
    logic        s_err_o;

    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_adr_i, s_sel_i, s_dat_i,
        input  s_dat_o, s_ack_o, s_err_o
    );

    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_adr_i, s_sel_i, s_dat_i,
        output s_dat_o, s_ack_o, s_err_o
    );
endinterface

// File: rtl/wb_data_slave.sv
// wb_data_slave: Wishbone 64-bit memory slave with fixed wait states and range error
module wb_data_slave #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = 12
) (
    input  logic            clk_i,
    input  logic            reset_i,
    wb_data_slave_if.slave  bus
);
    localparam int WORDS = 1 << (ADDR_BITS - 3);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-4:0] idx_q;
    logic                 we_q;
    logic                 in_q;
    logic [7:0]           sel_q;
    logic [63:0]          dat_q;
    logic [63:0]          mem [WORDS];

    logic                 req;
    logic                 in_range;
    logic                 enter_done;
    logic                 commit;
    logic                 idle;
    logic [ADDR_BITS-4:0] w_idx;
    logic [7:0]           w_sel;
    logic [63:0]          w_dat;
    logic                 unused_adr;

    assign unused_adr = ^bus.s_adr_i[2:0];
    assign idle       = state == IDLE;
    assign req        = bus.s_cyc_i & bus.s_stb_i;
    assign in_range   = ~|bus.s_adr_i[63:ADDR_BITS];

    // With zero wait states the write lands on the capture edge, so it must come from the live bus
    assign w_idx      = idle ? bus.s_adr_i[ADDR_BITS-1:3] : idx_q;
    assign w_sel      = idle ? bus.s_sel_i : sel_q;
    assign w_dat      = idle ? bus.s_dat_i : dat_q;
    assign enter_done = (idle & req & (WAIT_STATES == 0)) | (state == WAIT & bus.s_cyc_i & cnt == 4'd1);
    assign commit     = ~reset_i & enter_done & (idle ? bus.s_we_i & in_range : we_q & in_q);

    assign bus.s_ack_o = state == DONE & in_q;
    assign bus.s_err_o = state == DONE & ~in_q;
    assign bus.s_dat_o = (state == DONE & ~we_q & in_q) ? mem[idx_q] : '0;

    // Transfer sequencing: capture, count down wait states, one-clock DONE, abort on dropped cyc
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cnt   <= 4'(WAIT_STATES);
                        state <= (WAIT_STATES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.s_cyc_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request latch: frozen from capture so later bus changes cannot disturb the transfer
    always_ff @(posedge clk_i) begin
        if (idle && req) begin
            idx_q <= bus.s_adr_i[ADDR_BITS-1:3];
            we_q  <= bus.s_we_i;
            in_q  <= in_range;
            sel_q <= bus.s_sel_i;
            dat_q <= bus.s_dat_i;
        end
    end

    // Backing store: byte-lane write on the edge that enters DONE; never cleared by reset
    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 8; b++) begin
                if (w_sel[b]) mem[w_idx][8*b +: 8] <= w_dat[8*b +: 8];
            end
        end
    end
endmodule
